// File: rtl/kamus_csr_counters_if.sv
// CSR request/response bundle between the execute-stage CSR path and the counter unit.
// The master issues resolved reads/writes; the slave returns hit, data and status.
interface kamus_csr_counters_if;
    logic [11:0] csr_addr;
    logic        csr_re;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        csr_hit;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_illegal;

    modport master (
        output csr_addr, csr_re, csr_we, csr_wdata,
        input  csr_hit, csr_rdata, csr_rvalid, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_re, csr_we, csr_wdata,
        output csr_hit, csr_rdata, csr_rvalid, csr_illegal
    );
endinterface

// File: rtl/kamus_csr_counters.sv
// Machine cycle/time/instret counters with configurable width, mtime prescaler,
// per-counter inhibit and an mtime >= mtimecmp timer interrupt.
module kamus_csr_counters #(
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned TIME_DIV = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    kamus_csr_counters_if.slave csr,
    input  logic                instr_retire_i,
    output logic                timer_irq_o
);
    localparam logic [11:0] AddrMcycle    = 12'hF00;
    localparam logic [11:0] AddrMtime     = 12'hF01;
    localparam logic [11:0] AddrMinstret  = 12'hF02;
    localparam logic [11:0] AddrMcycleh   = 12'hF80;
    localparam logic [11:0] AddrMtimeh    = 12'hF81;
    localparam logic [11:0] AddrMinstreth = 12'hF82;
    localparam logic [11:0] AddrCycle     = 12'hC00;
    localparam logic [11:0] AddrTime      = 12'hC01;
    localparam logic [11:0] AddrInstret   = 12'hC02;
    localparam logic [11:0] AddrCycleh    = 12'hC80;
    localparam logic [11:0] AddrTimeh     = 12'hC81;
    localparam logic [11:0] AddrInstreth  = 12'hC82;
    localparam logic [11:0] AddrMtimecmp  = 12'h7C1;
    localparam logic [11:0] AddrMtimecmph = 12'h7C2;
    localparam logic [11:0] AddrMinhibit  = 12'h320;

    localparam logic [15:0] PrescLast = 16'(TIME_DIV - 1);

    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] mtime_q, mtime_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic [CNT_W-1:0] mtimecmp_q, mtimecmp_d;
    logic [15:0]      presc_q, presc_d;
    logic [2:0]       inhibit_q, inhibit_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             illegal_q, illegal_d;
    logic             irq_q, irq_d;

    logic        hit;
    logic        shadow;
    logic        wr_ok;
    logic [31:0] rd_val;
    logic        time_tick;

    // Halves are taken from a 64-bit zero-extended copy so narrow counters read 0 high.
    function automatic logic [31:0] half(input logic [CNT_W-1:0] v, input logic hi);
        logic [63:0] v64;
        v64 = 64'(v);
        return hi ? v64[63:32] : v64[31:0];
    endfunction

    // A high-half write keeps the low-half increment but drops its carry.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic             inc,
                                                  input logic             wr_lo,
                                                  input logic             wr_hi,
                                                  input logic [31:0]      wdata);
        logic [63:0] cur64;
        logic [63:0] nxt64;
        cur64 = 64'(cur);
        if (wr_lo) begin
            nxt64 = {cur64[63:32], wdata};
        end else if (wr_hi) begin
            nxt64 = {wdata, cur64[31:0] + 32'(inc)};
        end else begin
            nxt64 = cur64 + 64'(inc);
        end
        return CNT_W'(nxt64);
    endfunction

    always_comb begin
        hit    = 1'b1;
        rd_val = '0;
        case (csr.csr_addr)
            AddrMcycle,   AddrCycle:    rd_val = half(mcycle_q, 1'b0);
            AddrMcycleh,  AddrCycleh:   rd_val = half(mcycle_q, 1'b1);
            AddrMtime,    AddrTime:     rd_val = half(mtime_q, 1'b0);
            AddrMtimeh,   AddrTimeh:    rd_val = half(mtime_q, 1'b1);
            AddrMinstret, AddrInstret:  rd_val = half(minstret_q, 1'b0);
            AddrMinstreth, AddrInstreth: rd_val = half(minstret_q, 1'b1);
            AddrMtimecmp:               rd_val = half(mtimecmp_q, 1'b0);
            AddrMtimecmph:              rd_val = half(mtimecmp_q, 1'b1);
            AddrMinhibit:               rd_val = {29'd0, inhibit_q};
            default:                    hit    = 1'b0;
        endcase
        shadow = hit && (csr.csr_addr[11:8] == 4'hC);
        wr_ok  = csr.csr_we && hit && !shadow;
    end

    always_comb begin
        time_tick = !inhibit_q[1] && (presc_q == PrescLast);
        presc_d   = presc_q;
        if (!inhibit_q[1]) begin
            presc_d = time_tick ? 16'd0 : presc_q + 16'd1;
        end

        mcycle_d   = cnt_next(mcycle_q, !inhibit_q[0],
                              wr_ok && (csr.csr_addr == AddrMcycle),
                              wr_ok && (csr.csr_addr == AddrMcycleh), csr.csr_wdata);
        mtime_d    = cnt_next(mtime_q, time_tick,
                              wr_ok && (csr.csr_addr == AddrMtime),
                              wr_ok && (csr.csr_addr == AddrMtimeh), csr.csr_wdata);
        minstret_d = cnt_next(minstret_q, instr_retire_i && !inhibit_q[2],
                              wr_ok && (csr.csr_addr == AddrMinstret),
                              wr_ok && (csr.csr_addr == AddrMinstreth), csr.csr_wdata);
        mtimecmp_d = cnt_next(mtimecmp_q, 1'b0,
                              wr_ok && (csr.csr_addr == AddrMtimecmp),
                              wr_ok && (csr.csr_addr == AddrMtimecmph), csr.csr_wdata);

        inhibit_d = inhibit_q;
        if (wr_ok && (csr.csr_addr == AddrMinhibit)) begin
            inhibit_d = csr.csr_wdata[2:0];
        end

        rvalid_d  = csr.csr_re;
        rdata_d   = csr.csr_re ? rd_val : rdata_q;
        illegal_d = (csr.csr_re && !hit) || (csr.csr_we && (!hit || shadow));
        irq_d     = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_q   <= '0;
            mtime_q    <= '0;
            minstret_q <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            inhibit_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            illegal_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mcycle_q   <= mcycle_d;
            mtime_q    <= mtime_d;
            minstret_q <= minstret_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            inhibit_q  <= inhibit_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            illegal_q  <= illegal_d;
            irq_q      <= irq_d;
        end
    end

    assign csr.csr_hit     = hit;
    assign csr.csr_rdata   = rdata_q;
    assign csr.csr_rvalid  = rvalid_q;
    assign csr.csr_illegal = illegal_q;
    assign timer_irq_o     = irq_q;
endmodule
